// File: rtl/mem_master_pkg.sv
// Shared types and default geometry for the PicoComputer data-memory initiator.
package mem_master_pkg;

  localparam int unsigned MEM_ADDR_WIDTH = 6;
  localparam int unsigned MEM_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PTR    = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/mem_master.sv
// Load/store initiator for the 64x16 data memory, with direct and pointer-indirect addressing.
// Optional pointer range check is built when MEM_MASTER_BOUNDS_EN is defined.
module mem_master
  import mem_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = MEM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // a producer holds valid and its payload stable until that edge.
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_ind,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_out,
  output state_e                dbg_state
);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  abort;
  logic                  ptr_oob;

  // Pointer bits above the address field; always zero when the widths match.
  assign ptr_oob = (mem_out >> ADDR_WIDTH) != '0;

`ifdef MEM_MASTER_BOUNDS_EN
  logic err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  always_comb begin
    err_d = err_q;
    if (state_q == PTR && ptr_oob)                     err_d = 1'b1;
    else if (state_q == DONE && rsp_ready)             err_d = 1'b0;
  end

  assign abort   = err_q;
  assign rsp_err = err_q;
`else
  logic unused_ptr_oob;
  assign unused_ptr_oob = ptr_oob;
  assign abort   = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // mem_addr_q doubles as the address/pointer register: it holds req_addr for
  // PTR and direct ACCESS, and is reloaded with the truncated pointer for
  // indirect ACCESS, so the memory pins always come straight from flops.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    rsp_data_d = rsp_data_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d       = req_we;
          mem_addr_d = req_addr;
          if (req_we) mem_data_d = req_data;
          state_d    = req_ind ? PTR : ACCESS;
        end
      end
      PTR: begin
        mem_addr_d = mem_out[ADDR_WIDTH-1:0];
        state_d    = ACCESS;
      end
      ACCESS: begin
        rsp_data_d = (we_q || abort) ? '0 : mem_out;
        state_d    = DONE;
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Decoded from state_q so an asynchronous reset drops the write strobe at once.
  assign mem_we    = (state_q == ACCESS) && we_q && !abort;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_data  = rsp_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master with a behavioural 64x16 memory attached to its pins.
module tb_mem_master;
  import mem_master_pkg::*;

  localparam int AW = 6;
  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          req_valid, req_ready, req_we, req_ind;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_data, mem_out;
  state_e        dbg_state;

  logic [DW-1:0] mem [64];

  int checks;
  int errors;

  mem_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_ind   (req_ind),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_data  (mem_data),
    .mem_out   (mem_out),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: combinational read, write on clk edge
  assign mem_out = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data;
  end

  // driver: present a request at a falling edge, hold it over one rising edge,
  // withdraw it at the next falling edge (cycle 1 after accept)
  task automatic send_req(input logic we, input logic ind, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_ind   = ind;
    req_addr  = addr;
    req_data  = data;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_data !== 16'h0) begin errors++; $display("FAIL reset_rsp_data got %h exp 0000", rsp_data); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
    checks++; if (mem_addr !== 6'd0) begin errors++; $display("FAIL reset_mem_addr got %0d exp 0", mem_addr); end
    checks++; if (mem_data !== 16'h0) begin errors++; $display("FAIL reset_mem_data got %h exp 0000", mem_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_direct();
    send_req(1'b1, 1'b0, 6'd5, 16'hBEEF);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL dst_we got %b exp 1", mem_we); end
    checks++; if (mem_addr !== 6'd5) begin errors++; $display("FAIL dst_addr got %0d exp 5", mem_addr); end
    checks++; if (mem_data !== 16'hBEEF) begin errors++; $display("FAIL dst_data got %h exp beef", mem_data); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL dst_rsp_valid got %b exp 1", rsp_valid); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL dst_we_drop got %b exp 0", mem_we); end
    checks++; if (rsp_data !== 16'h0) begin errors++; $display("FAIL dst_rsp_data got %h exp 0000", rsp_data); end
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL dst_back_idle got %b exp 1", req_ready); end
    checks++; if (mem[5] !== 16'hBEEF) begin errors++; $display("FAIL dst_mem5 got %h exp beef", mem[5]); end
    send_req(1'b0, 1'b0, 6'd5, 16'h0000);
    checks++; if (mem_we !== 1'b0 || mem_addr !== 6'd5 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL dld_access got we=%b addr=%0d rv=%b exp we=0 addr=5 rv=0", mem_we, mem_addr, rsp_valid);
    end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'hBEEF || rsp_err !== 1'b0) begin
      errors++; $display("FAIL dld_rsp got rv=%b data=%h err=%b exp rv=1 data=beef err=0", rsp_valid, rsp_data, rsp_err);
    end
    @(negedge clk);
  endtask

  task automatic test_indirect_load();
    mem[3]  = 16'h0012;
    mem[18] = 16'h1234;
    send_req(1'b0, 1'b1, 6'd3, 16'h0000);
    checks++; if (mem_addr !== 6'd3 || mem_we !== 1'b0) begin
      errors++; $display("FAIL ild_ptr got addr=%0d we=%b exp addr=3 we=0", mem_addr, mem_we);
    end
    @(negedge clk);
    checks++; if (mem_addr !== 6'd18 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL ild_access got addr=%0d rv=%b exp addr=18 rv=0", mem_addr, rsp_valid);
    end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h1234) begin
      errors++; $display("FAIL ild_rsp got rv=%b data=%h exp rv=1 data=1234", rsp_valid, rsp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_indirect_store();
    mem[7] = 16'h0020;
    send_req(1'b1, 1'b1, 6'd7, 16'hA5A5);
    checks++; if (mem_we !== 1'b0 || mem_addr !== 6'd7) begin
      errors++; $display("FAIL ist_ptr got we=%b addr=%0d exp we=0 addr=7", mem_we, mem_addr);
    end
    @(negedge clk);
    checks++; if (mem_we !== 1'b1 || mem_addr !== 6'd32 || mem_data !== 16'hA5A5) begin
      errors++; $display("FAIL ist_access got we=%b addr=%0d data=%h exp we=1 addr=32 data=a5a5", mem_we, mem_addr, mem_data);
    end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0) begin
      errors++; $display("FAIL ist_rsp got rv=%b data=%h exp rv=1 data=0000", rsp_valid, rsp_data);
    end
    checks++; if (mem[32] !== 16'hA5A5 || mem[7] !== 16'h0020) begin
      errors++; $display("FAIL ist_mem got m32=%h m7=%h exp m32=a5a5 m7=0020", mem[32], mem[7]);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    send_req(1'b0, 1'b0, 6'd18, 16'h0000);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h1234 || req_ready !== 1'b0 || mem_we !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got rv=%b data=%h rr=%b we=%b exp rv=1 data=1234 rr=0 we=0",
                 i, rsp_valid, rsp_data, req_ready, mem_we);
      end
      req_valid = (i == 1);
      req_we    = 1'b1;
      req_ind   = 1'b0;
      req_addr  = 6'd0;
      req_data  = 16'hFFFF;
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got rr=%b rv=%b exp rr=1 rv=0", req_ready, rsp_valid);
    end
    checks++; if (mem[0] !== 16'h0000) begin
      errors++; $display("FAIL bp_ignored_req got m0=%h exp 0000", mem[0]);
    end
  endtask

  task automatic test_reset_mid_op();
    send_req(1'b1, 1'b0, 6'd9, 16'h1111);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rst_pre_we got %b exp 1", mem_we); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0 || mem_addr !== 6'd0 || mem_data !== 16'h0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_async got we=%b addr=%0d data=%h rr=%b rv=%b exp we=0 addr=0 data=0000 rr=1 rv=0",
               mem_we, mem_addr, mem_data, req_ready, rsp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || mem_we !== 1'b0) begin
        errors++; $display("FAIL rst_after[%0d] got rv=%b we=%b exp rv=0 we=0", i, rsp_valid, mem_we);
      end
    end
    checks++; if (mem[9] !== 16'h0000) begin
      errors++; $display("FAIL rst_no_write got m9=%h exp 0000", mem[9]);
    end
  endtask

  task automatic test_bounds();
    mem[2] = 16'h0140;
    send_req(1'b1, 1'b1, 6'd2, 16'h5A5A);
    @(negedge clk);
`ifdef MEM_MASTER_BOUNDS_EN
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL bnd_we got %b exp 0", mem_we); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 16'h0) begin
      errors++; $display("FAIL bnd_rsp got rv=%b err=%b data=%h exp rv=1 err=1 data=0000", rsp_valid, rsp_err, rsp_data);
    end
    checks++; if (mem[0] !== 16'h0000) begin errors++; $display("FAIL bnd_mem0 got %h exp 0000", mem[0]); end
    @(negedge clk);
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL bnd_err_clear got %b exp 0", rsp_err); end
`else
    checks++; if (mem_we !== 1'b1 || mem_addr !== 6'd0) begin
      errors++; $display("FAIL trunc_access got we=%b addr=%0d exp we=1 addr=0", mem_we, mem_addr);
    end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL trunc_rsp got rv=%b err=%b exp rv=1 err=0", rsp_valid, rsp_err);
    end
    checks++; if (mem[0] !== 16'h5A5A) begin errors++; $display("FAIL trunc_mem0 got %h exp 5a5a", mem[0]); end
    @(negedge clk);
`endif
  endtask

  task automatic test_back_to_back();
    // rsp_ready held high: direct requests complete every 3 cycles
    mem[40] = 16'h0C0C;
    mem[41] = 16'h0D0D;
    send_req(1'b0, 1'b0, 6'd40, 16'h0);
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0C0C) begin
      errors++; $display("FAIL b2b_first got rv=%b data=%h exp rv=1 data=0c0c", rsp_valid, rsp_data);
    end
    send_req(1'b0, 1'b0, 6'd41, 16'h0);
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0D0D) begin
      errors++; $display("FAIL b2b_second got rv=%b data=%h exp rv=1 data=0d0d", rsp_valid, rsp_data);
    end
    @(negedge clk);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_ind   = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    test_reset();
    test_direct();
    test_indirect_load();
    test_indirect_store();
    test_backpressure();
    test_reset_mid_op();
    test_bounds();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_master.md
Name: mem_master

Overview:
- Bus initiator between the PicoComputer CPU datapath and the 64x16 data memory.
- Accepts one load/store request at a time over a valid/ready handshake.
- Supports direct and indirect (pointer-in-memory) addressing.
- Drives the memory's addr/we/data pins and returns load data, or completion, over a valid/ready response channel.
- The memory reads combinationally and writes on the clk edge.

Parameters:
- ADDR_WIDTH, 6, memory address width; memory depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 16, memory word width; must be >= ADDR_WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request; equals (state==IDLE).
- req_we  input  1  1 = store, 0 = load.
- req_ind  input  1  1 = indirect: effective address = low ADDR_WIDTH bits of mem[req_addr].
- req_addr  input  ADDR_WIDTH  direct address or pointer location.
- req_data  input  DATA_WIDTH  store data.
- rsp_valid  output  1  response present; held until accepted.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data  output  DATA_WIDTH  load data; 0 for stores.
- rsp_err  output  1  access aborted (only with the optional feature).
- mem_addr  output  ADDR_WIDTH  to memory addr.
- mem_we  output  1  to memory we.
- mem_data  output  DATA_WIDTH  to memory data.
- mem_out  input  DATA_WIDTH  from memory out (combinational read).

Behaviour:
- States: IDLE, PTR, ACCESS, DONE.
- Reset (async) forces IDLE and clears all registers.
  - Reset values: req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, mem_we=0, mem_addr=0, mem_data=0.
  - An in-flight request is dropped and no response is issued.
  - A store in PTR/ACCESS when rst_n falls never completes: mem_we deasserts asynchronously.
- IDLE:
  - On req_valid&&req_ready at an edge, latch we_q, ind_q, addr_q, data_q.
  - Go to PTR if req_ind, else to ACCESS.
- PTR (one cycle):
  - mem_addr=addr_q, mem_we=0.
  - At the edge, capture ptr_q=mem_out; go to ACCESS.
- ACCESS (one cycle):
  - mem_addr = ind_q ? ptr_q[ADDR_WIDTH-1:0] : addr_q.
  - Store: mem_we=1 and mem_data=data_q for exactly this cycle; rsp_data loaded 0.
  - Load: mem_we=0; rsp_data captures mem_out at the edge.
  - Go to DONE.
- DONE:
  - rsp_valid=1; rsp_data and rsp_err stable.
  - On rsp_ready at an edge, go to IDLE and drop rsp_valid.
- Latency, accept edge to first rsp_valid cycle: direct 2 cycles, indirect 3 cycles.
  - With rsp_ready tied 1: throughput one request per 3 (direct) or 4 (indirect) cycles.
- Outputs outside PTR/ACCESS: mem_we=0; mem_addr and mem_data hold their last driven values (registered, glitch-free).
- mem_we is never asserted outside ACCESS.
- Request inputs are ignored outside IDLE.
- req_valid may drop without acceptance; no effect.
- Indirect store whose pointer equals req_addr overwrites the pointer cell; legal.
- Pointer upper bits [DATA_WIDTH-1:ADDR_WIDTH] are silently truncated (without the feature).

Optional Feature:
- MEM_MASTER_BOUNDS_EN
- Defined:
  - In PTR, if ptr upper bits [DATA_WIDTH-1:ADDR_WIDTH] are not all zero, set err_q and still pass through ACCESS.
  - mem_we is forced 0 and rsp_data is 0 for that access.
  - DONE presents rsp_err=1; err_q clears on return to IDLE.
  - Direct accesses never error.
- Undefined:
  - No check; truncation as above.
  - rsp_err is a constant 0 and the err_q flop is not built.

Decomposition:
- Package mem_master_pkg:
  - State enum (IDLE, PTR, ACCESS, DONE, 2-bit).
  - Default ADDR_WIDTH/DATA_WIDTH constants shared with the memory block.
- No sub-module: a single FSM with the request/response registers is natural.
- The effective-address mux stays inline.

Test Plan:
- Direct store/load: store addr=5 data=16'hBEEF, then load addr=5.
  - mem_we high one cycle with mem_addr=5.
  - Load rsp_valid 2 cycles after accept with rsp_data=16'hBEEF, rsp_err=0.
- Indirect load:
  - Preload mem[3]=16'h0012, mem[18]=16'h1234; load ind addr=3.
  - PTR cycle mem_addr=3, ACCESS cycle mem_addr=18.
  - rsp_data=16'h1234 at 3 cycles.
- Indirect store: mem[7]=16'h0020; store ind addr=7 data=16'hA5A5 -> mem[32]=16'hA5A5, mem[7] unchanged.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles after rsp_valid.
  - rsp_valid/rsp_data stable and req_ready=0 throughout.
  - A req_valid pulse during this window is ignored.
- Reset mid-operation:
  - Assert rst_n=0 during the ACCESS cycle of a store to addr=9.
  - All outputs go to reset values at once; mem_we never pulses; no rsp_valid after release.
- With MEM_MASTER_BOUNDS_EN: mem[2]=16'h0140; store ind addr=2 -> mem_we stays 0, rsp_err=1, rsp_data=0.
  - Without the macro: mem[0]=data (truncated pointer), rsp_err=0.
